// File: rtl/wr_arria10_phy_reset_ctrl.sv
// rtl/wr_arria10_phy_reset_ctrl.sv - Arria 10 WR PHY reset/lock sequencer; optional LTD timeout via WR_A10_PHY_RST_LTD_TIMEOUT_EN
module wr_arria10_phy_reset_ctrl #(
    parameter int TX_ARST_CYC     = 16,
    parameter int RX_ARST_CYC     = 16,
    parameter int DRST_CYC        = 8,
    parameter int LTD_STABLE_CYC  = 64,
    parameter int LTD_TIMEOUT_CYC = 4096
) (
    input  logic clk_sys_i,
    input  logic rst_n_i,
    input  logic tx_cal_busy_i,
    input  logic rx_cal_busy_i,
    input  logic tx_pll_locked_i,
    input  logic rx_is_lockedtoref_i,
    input  logic rx_is_lockedtodata_i,
    input  logic rx_restart_i,
    output logic tx_analogreset_o,
    output logic tx_digitalreset_o,
    output logic rx_analogreset_o,
    output logic rx_digitalreset_o,
    output logic rx_set_locktoref_o,
    output logic rx_set_locktodata_o,
    output logic tx_ready_o,
    output logic rx_ready_o,
    output logic rx_timeout_o
);

    localparam int MAX_A = (TX_ARST_CYC > RX_ARST_CYC) ? TX_ARST_CYC : RX_ARST_CYC;
    localparam int MAX_B = (DRST_CYC > LTD_STABLE_CYC) ? DRST_CYC : LTD_STABLE_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > LTD_TIMEOUT_CYC) ? MAX_C : LTD_TIMEOUT_CYC;
    localparam int CW    = $clog2(MAX_P) + 1;

    // Synchronizer bit order: restart, ltd, ltr, pll, rx_cal, tx_cal.
    // Cal-busy bits come out of reset as busy so S_CAL never leaves on stale data.
    localparam logic [5:0] SYNC_RST = 6'b000011;

    typedef enum logic [3:0] {
        S_CAL, S_TX_ARST, S_TX_PLL, S_TX_DRST,
        S_RX_ARST, S_RX_LTR, S_RX_LTD, S_RX_DRST, S_READY
    } state_t;

    logic [5:0]    sync_meta_q, sync_meta_d, sync_q, sync_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          tx_arst_q, tx_arst_d, tx_drst_q, tx_drst_d;
    logic          rx_arst_q, rx_arst_d, rx_drst_q, rx_drst_d;
    logic          ltr_q, ltr_d, tx_rdy_q, tx_rdy_d, rx_rdy_q, rx_rdy_d;
    logic          tx_cal, rx_cal, pll, ltr_in, ltd_in, restart_in;

    assign tx_cal     = sync_q[0];
    assign rx_cal     = sync_q[1];
    assign pll        = sync_q[2];
    assign ltr_in     = sync_q[3];
    assign ltd_in     = sync_q[4];
    assign restart_in = sync_q[5];

`ifdef WR_A10_PHY_RST_LTD_TIMEOUT_EN
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;

    // Lock-to-data timeout counter and one-cycle timeout pulse register
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign rx_timeout_o = timeout_q;
`else
    assign rx_timeout_o = 1'b0;
`endif

    // Two-stage synchronizer next values
    always_comb begin
        sync_meta_d = {rx_restart_i, rx_is_lockedtodata_i, rx_is_lockedtoref_i,
                       tx_pll_locked_i, rx_cal_busy_i, tx_cal_busy_i};
        sync_d      = sync_meta_q;
    end

    // State, counter, synchronizer and registered output flops
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_meta_q <= SYNC_RST;
            sync_q      <= SYNC_RST;
            state_q     <= S_CAL;
            cnt_q       <= '0;
            tx_arst_q   <= 1'b1;
            tx_drst_q   <= 1'b1;
            rx_arst_q   <= 1'b1;
            rx_drst_q   <= 1'b1;
            ltr_q       <= 1'b0;
            tx_rdy_q    <= 1'b0;
            rx_rdy_q    <= 1'b0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_arst_q   <= tx_arst_d;
            tx_drst_q   <= tx_drst_d;
            rx_arst_q   <= rx_arst_d;
            rx_drst_q   <= rx_drst_d;
            ltr_q       <= ltr_d;
            tx_rdy_q    <= tx_rdy_d;
            rx_rdy_q    <= rx_rdy_d;
        end
    end

    // Next state, hold counter, restart priority and output decode from next state
    always_comb begin
        state_d = state_q;
        cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_inc;
`ifdef WR_A10_PHY_RST_LTD_TIMEOUT_EN
        timeout_d = 1'b0;
        to_cnt_d  = '0;
        if (state_q == S_RX_LTD)
            to_cnt_d = (to_cnt_q == {CW{1'b1}}) ? to_cnt_q : to_cnt_q + 1'b1;
`endif

        case (state_q)
            S_CAL:     if (!tx_cal && !rx_cal) state_d = S_TX_ARST;
            S_TX_ARST: if (cnt_q == CW'(TX_ARST_CYC - 1)) state_d = S_TX_PLL;
            S_TX_PLL:  if (pll) state_d = S_TX_DRST;
            S_TX_DRST: if (cnt_q == CW'(DRST_CYC - 1)) state_d = S_RX_ARST;
            S_RX_ARST: if (cnt_q == CW'(RX_ARST_CYC - 1)) state_d = S_RX_LTR;
            S_RX_LTR:  if (ltr_in) state_d = S_RX_LTD;
            S_RX_LTD: begin
                if (!ltd_in)
                    cnt_d = '0;
                else if (cnt_q == CW'(LTD_STABLE_CYC - 1))
                    state_d = S_RX_DRST;
            end
            S_RX_DRST: if (cnt_q == CW'(DRST_CYC - 1)) state_d = S_READY;
            S_READY:   state_d = S_READY;
            default:   state_d = S_CAL;
        endcase

        // RX re-sequence; losing data lock only matters once lock was declared stable
        if (state_q inside {S_RX_LTD, S_RX_DRST, S_READY} &&
            (restart_in || (!ltd_in && state_q != S_RX_LTD)))
            state_d = S_RX_ARST;

`ifdef WR_A10_PHY_RST_LTD_TIMEOUT_EN
        if (state_q == S_RX_LTD && state_d == S_RX_LTD &&
            to_cnt_q == CW'(LTD_TIMEOUT_CYC - 1)) begin
            state_d   = S_RX_ARST;
            timeout_d = 1'b1;
        end
`endif

        // TX-side loss overrides any RX condition in the same cycle
        if (state_q inside {[S_TX_DRST:S_READY]} && (!pll || tx_cal || rx_cal))
            state_d = S_CAL;

        if (state_d != state_q)
            cnt_d = '0;

        tx_arst_d = state_d inside {S_CAL, S_TX_ARST};
        tx_drst_d = state_d inside {[S_CAL:S_TX_DRST]};
        rx_arst_d = state_d inside {[S_CAL:S_RX_ARST]};
        rx_drst_d = state_d inside {[S_CAL:S_RX_DRST]};
        ltr_d     = state_d inside {S_RX_ARST, S_RX_LTR};
        tx_rdy_d  = state_d inside {[S_RX_ARST:S_READY]};
        rx_rdy_d  = (state_d == S_READY);
    end

    assign tx_analogreset_o    = tx_arst_q;
    assign tx_digitalreset_o   = tx_drst_q;
    assign rx_analogreset_o    = rx_arst_q;
    assign rx_digitalreset_o   = rx_drst_q;
    assign rx_set_locktoref_o  = ltr_q;
    assign rx_set_locktodata_o = 1'b0;
    assign tx_ready_o          = tx_rdy_q;
    assign rx_ready_o          = rx_rdy_q;

endmodule

// File: tb/tb_wr_arria10_phy_reset_ctrl.sv
// tb/tb_wr_arria10_phy_reset_ctrl.sv - directed bench for wr_arria10_phy_reset_ctrl
module tb_wr_arria10_phy_reset_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_cal = 1'b1, rx_cal = 1'b1, pll = 1'b0, ltr = 1'b1, ltd = 1'b1, restart = 1'b0;
    logic tx_a, tx_d, rx_a, rx_d, ltr_o, ltd_o, tx_r, rx_r, to_o;
    logic [8:0] outs;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int rel, d0, l0, f0;

    int t_txa, t_txd, t_rxa, t_rxa_rise, t_rxd, t_txr, t_txr_fall, t_rxr, t_rxr_fall, t_ltr_fall, t_to1, t_to2, n_to;
    logic p_txa = 1'b1, p_txd = 1'b1, p_rxa = 1'b1, p_rxd = 1'b1, p_txr = 1'b0, p_rxr = 1'b0, p_ltr = 1'b0;

    wr_arria10_phy_reset_ctrl dut (
        .clk_sys_i           (clk),
        .rst_n_i             (rst_n),
        .tx_cal_busy_i       (tx_cal),
        .rx_cal_busy_i       (rx_cal),
        .tx_pll_locked_i     (pll),
        .rx_is_lockedtoref_i (ltr),
        .rx_is_lockedtodata_i(ltd),
        .rx_restart_i        (restart),
        .tx_analogreset_o    (tx_a),
        .tx_digitalreset_o   (tx_d),
        .rx_analogreset_o    (rx_a),
        .rx_digitalreset_o   (rx_d),
        .rx_set_locktoref_o  (ltr_o),
        .rx_set_locktodata_o (ltd_o),
        .tx_ready_o          (tx_r),
        .rx_ready_o          (rx_r),
        .rx_timeout_o        (to_o)
    );

    assign outs = {tx_a, tx_d, rx_a, rx_d, ltr_o, ltd_o, tx_r, rx_r, to_o};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge-time recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (p_txa && !tx_a) t_txa = cyc;
            if (p_txd && !tx_d) t_txd = cyc;
            if (p_rxa && !rx_a) t_rxa = cyc;
            if (!p_rxa && rx_a) t_rxa_rise = cyc;
            if (p_rxd && !rx_d) t_rxd = cyc;
            if (!p_txr && tx_r) t_txr = cyc;
            if (p_txr && !tx_r) t_txr_fall = cyc;
            if (!p_rxr && rx_r) t_rxr = cyc;
            if (p_rxr && !rx_r) t_rxr_fall = cyc;
            if (p_ltr && !ltr_o) t_ltr_fall = cyc;
            if (to_o) begin
                n_to = n_to + 1;
                if (n_to == 1) t_to1 = cyc;
                else if (n_to == 2) t_to2 = cyc;
            end
        end
        p_txa = tx_a; p_txd = tx_d; p_rxa = rx_a; p_rxd = rx_d;
        p_txr = tx_r; p_rxr = rx_r; p_ltr = ltr_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic arm();
        t_txa = -1; t_txd = -1; t_rxa = -1; t_rxa_rise = -1; t_rxd = -1; t_txr = -1;
        t_txr_fall = -1; t_rxr = -1; t_rxr_fall = -1; t_ltr_fall = -1;
        t_to1 = -1; t_to2 = -1; n_to = 0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        arm();
        // Reset values, cal already done and all locks present
        tx_cal = 1'b0; rx_cal = 1'b0; pll = 1'b1; ltr = 1'b1; ltd = 1'b1;
        @(negedge clk);
        check("reset_outs", outs, 9'b1111_0000_0);
        wait_cyc(4);
        rst_n = 1'b1;
        rel = cyc;
        wait_cyc(rel + 125);
        check("a_txa_fall", t_txa - rel, 19);
        check("a_txd_fall", t_txd - rel, 28);
        check("a_rxa_fall", t_rxa - rel, 44);
        check("a_ltr_fall", t_ltr_fall - rel, 45);
        check("a_rxd_fall", t_rxd - rel, 117);
        check("a_ready", {tx_r, rx_r}, 2'b11);

        // Power-up: cal busy 100 cycles, PLL lock 50 cycles later
        rst_n = 1'b0; tx_cal = 1'b1; rx_cal = 1'b1; pll = 1'b0;
        arm();
        wait_cyc(cyc + 3);
        rst_n = 1'b1;
        rel = cyc;
        wait_cyc(rel + 100);
        tx_cal = 1'b0; rx_cal = 1'b0;
        wait_cyc(rel + 150);
        pll = 1'b1;
        wait_cyc(rel + 260);
        check("b_txa_fall", t_txa - rel, 119);
        check("b_txd_fall", t_txd - rel, 161);
        check("b_txr_rise", t_txr - rel, 161);
        check("b_rxa_fall", t_rxa - rel, 177);
        check("b_rxd_fall", t_rxd - rel, 250);
        check("b_rxr_rise", t_rxr - rel, 250);

        // Data-lock loss in READY, then a glitch at stable count 63
        arm();
        d0 = cyc;
        ltd = 1'b0;
        wait_cyc(d0 + 1);
        ltd = 1'b1;
        l0 = d0 + 20;
        wait_cyc(l0 + 61);
        ltd = 1'b0;
        wait_cyc(l0 + 62);
        ltd = 1'b1;
        wait_cyc(l0 + 140);
        check("c_rxr_fall", t_rxr_fall - d0, 3);
        check("c_rxa_rise", t_rxa_rise - d0, 3);
        check("c_rxa_fall", t_rxa - d0, 19);
        check("c_ltr_fall", t_ltr_fall - d0, 20);
        check("c_txr_kept", t_txr_fall, -1);
        check("c_rxr_glitch", t_rxr - l0, 136);

        // PLL loss and RX restart together: full restart wins
        f0 = cyc;
        pll = 1'b0; restart = 1'b1;
        wait_cyc(f0 + 2);
        check("d_ready_pre", {tx_r, rx_r}, 2'b11);
        wait_cyc(f0 + 3);
        check("d_full_rst", outs, 9'b1111_0000_0);

        // Async reset while in S_RX_DRST
        pll = 1'b1; restart = 1'b0;
        arm();
        wait_cyc(f0 + 112);
        check("e_ltr_fall", t_ltr_fall - f0, 46);
        check("e_in_drst", outs, 9'b0001_0010_0);
        #3;
        rst_n = 1'b0;
        #1;
        check("e_async_rst", outs, 9'b1111_0000_0);

        // Data lock never arrives
        ltd = 1'b0;
        arm();
        wait_cyc(cyc + 3);
        rst_n = 1'b1;
        rel = cyc;
        wait_cyc(rel + 8300);
`ifdef WR_A10_PHY_RST_LTD_TIMEOUT_EN
        check("f_to_count", n_to, 2);
        check("f_to_first", t_to1 - rel, 4141);
        check("f_to_period", t_to2 - t_to1, 4113);
`else
        check("f_no_timeout", n_to, 0);
`endif
        check("f_rx_not_ready", {tx_r, rx_r}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
